// File: rtl/alt_vipitc131_common_sample_position_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alt_vipitc131_common_sample_position_counter_pkg               |
// | Purpose  : Shared types and helpers for the sample position counter:      |
// |            the HD/SD mode encoding and the single-cycle-sample rule.      |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package alt_vipitc131_common_sample_position_counter_pkg;

   // hd_sdn encoding: HD carries a whole sample per cycle, SD sequences planes
   typedef enum logic {
      MODE_SD = 1'b0,
      MODE_HD = 1'b1
   } mode_e;

   // A sample occupies one cycle when there is only one plane, when planes
   // arrive side by side, or when the link runs in HD mode.
   function automatic logic single_cycle_sample(input int    planes,
                                                input int    parallel,
                                                input mode_e mode);
      return (planes == 1) || (parallel != 0) || (mode == MODE_HD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alt_vipitc131_common_sample_position_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alt_vipitc131_common_sample_position_counter_if                |
// | Purpose  : Bundles the control inputs and position/strobe outputs of the  |
// |            sample position counter.                                       |
// | Ports    : master drives sclr/count_cycle/hd_sdn/geometry and observes    |
// |            the counts and strobes; slave is the counter side.             |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface alt_vipitc131_common_sample_position_counter_if #(
   parameter int H_COUNT_WIDTH                = 12,
   parameter int V_COUNT_WIDTH                = 12,
   parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
);
   logic                                    sclr;
   logic                                    count_cycle;
   logic                                    hd_sdn;
   logic [H_COUNT_WIDTH-1:0]                active_width;
   logic [V_COUNT_WIDTH-1:0]                active_height;
   logic                                    count_sample;
   logic                                    start_of_sample;
   logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks;
   logic [H_COUNT_WIDTH-1:0]                h_count;
   logic [V_COUNT_WIDTH-1:0]                v_count;
   logic                                    end_of_line;
   logic                                    end_of_frame;
   logic                                    start_of_frame;

   modport master (
      output sclr, count_cycle, hd_sdn, active_width, active_height,
      input  count_sample, start_of_sample, sample_ticks, h_count, v_count,
             end_of_line, end_of_frame, start_of_frame
   );

   modport slave (
      input  sclr, count_cycle, hd_sdn, active_width, active_height,
      output count_sample, start_of_sample, sample_ticks, h_count, v_count,
             end_of_line, end_of_frame, start_of_frame
   );
endinterface
`default_nettype wire

// File: rtl/alt_vipitc131_common_wrap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alt_vipitc131_common_wrap_counter                              |
// | Purpose  : Position counter that advances by STEP and wraps to zero once  |
// |            the next position would reach limit.                           |
// | Ports    : clk, rst_n   clock / async active-low reset                    |
// |            inc          advance (or wrap) this cycle                      |
// |            sclr         treat the count as sclr_val this cycle            |
// |            sclr_val     restart value                                     |
// |            limit        wrap limit (0 behaves as STEP)                    |
// |            count        registered position                               |
// |            last         comb: current position is the last one            |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module alt_vipitc131_common_wrap_counter #(
   parameter int WIDTH = 12,
   parameter int STEP  = 1
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             inc,
   input  wire logic             sclr,
   input  wire logic [WIDTH-1:0] sclr_val,
   input  wire logic [WIDTH-1:0] limit,
   output logic      [WIDTH-1:0] count,
   output logic                  last
);
   localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_eff;
   logic [WIDTH:0]   w_limit_eff;
   logic [WIDTH:0]   w_reach;

   // A restart makes this very cycle the first position of the new frame.
   assign w_count_eff = sclr ? sclr_val : r_count;
   assign w_limit_eff = (limit == '0) ? c_step : {1'b0, limit};
   // One extra bit so count+STEP near full scale cannot wrap past the limit.
   assign w_reach     = {1'b0, w_count_eff} + c_step;
   assign last        = (w_reach >= w_limit_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= last ? '0 : w_reach[WIDTH-1:0];
      end else if (sclr) begin
         r_count <= sclr_val;
      end
   end

   assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/alt_vipitc131_common_sample_position_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alt_vipitc131_common_sample_position_counter                   |
// | Purpose  : Tracks colour-plane tick, pixel and line position for the      |
// |            clocked-video-output timing path and emits sample/line/frame   |
// |            strobes. Mode and geometry are shadowed at frame boundaries.   |
// | Ports    : clk, rst_n  clock / async active-low reset                     |
// |            bus (slave) sclr, count_cycle, hd_sdn, active_width/height in; |
// |                        count_sample, start_of_sample, sample_ticks,       |
// |                        h_count, v_count, end_of_line, end_of_frame,       |
// |                        start_of_frame out                                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module alt_vipitc131_common_sample_position_counter
   import alt_vipitc131_common_sample_position_counter_pkg::*;
#(
   parameter int NUMBER_OF_COLOUR_PLANES       = 3,
   parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
   parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
   parameter int PIXELS_IN_PARALLEL            = 1,
   parameter int H_COUNT_WIDTH                 = 12,
   parameter int V_COUNT_WIDTH                 = 12,
   parameter int DEFAULT_WIDTH                 = 1920,
   parameter int DEFAULT_HEIGHT                = 1080
) (
   input wire logic clk,
   input wire logic rst_n,
   alt_vipitc131_common_sample_position_counter_if.slave bus
);
   localparam int                                c_l = LOG2_NUMBER_OF_COLOUR_PLANES;
   localparam logic [c_l-1:0]                    c_last_tick = c_l'(NUMBER_OF_COLOUR_PLANES - 1);

   mode_e                    r_mode;
   logic [H_COUNT_WIDTH-1:0] r_width;
   logic [V_COUNT_WIDTH-1:0] r_height;
   logic [c_l-1:0]           r_tick;

   mode_e                    w_mode_eff;
   logic [H_COUNT_WIDTH-1:0] w_width_eff;
   logic [V_COUNT_WIDTH-1:0] w_height_eff;
   logic [c_l-1:0]           w_tick_eff;
   logic                     w_single;
   logic                     w_last_plane;
   logic                     w_sos;
   logic                     w_count_sample;
   logic                     w_h_last;
   logic                     w_v_last;
   logic                     w_eol;
   logic                     w_eof;
   logic [H_COUNT_WIDTH-1:0] w_h_count;
   logic [V_COUNT_WIDTH-1:0] w_v_count;

   // On sclr the cycle belongs to the new frame: live mode/geometry apply and
   // the plane tick is taken as zero.
   assign w_mode_eff   = bus.sclr ? mode_e'(bus.hd_sdn) : r_mode;
   assign w_width_eff  = bus.sclr ? bus.active_width    : r_width;
   assign w_height_eff = bus.sclr ? bus.active_height   : r_height;
   assign w_tick_eff   = bus.sclr ? '0                  : r_tick;

   assign w_single       = single_cycle_sample(NUMBER_OF_COLOUR_PLANES,
                                               COLOUR_PLANES_ARE_IN_PARALLEL, w_mode_eff);
   assign w_last_plane   = w_single | (w_tick_eff == c_last_tick);
   assign w_sos          = w_single | (w_tick_eff == '0);
   assign w_count_sample = bus.count_cycle & w_last_plane;
   assign w_eol          = w_count_sample & w_h_last;
   assign w_eof          = w_eol & w_v_last;

   // Plane tick: held in single-cycle mode, otherwise cycles 0..planes-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= '0;
      end else if (bus.count_cycle) begin
         r_tick <= w_last_plane ? '0 : w_tick_eff + c_l'(1);
      end else begin
         r_tick <= w_tick_eff;
      end
   end

   // Shadows change only at a frame boundary so a frame is never split.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= MODE_SD;
         r_width  <= H_COUNT_WIDTH'(DEFAULT_WIDTH);
         r_height <= V_COUNT_WIDTH'(DEFAULT_HEIGHT);
      end else if (bus.sclr | w_eof) begin
         r_mode   <= mode_e'(bus.hd_sdn);
         r_width  <= bus.active_width;
         r_height <= bus.active_height;
      end
   end

   alt_vipitc131_common_wrap_counter #(
      .WIDTH (H_COUNT_WIDTH),
      .STEP  (PIXELS_IN_PARALLEL)
   ) u_h_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (w_count_sample),
      .sclr     (bus.sclr),
      .sclr_val ('0),
      .limit    (w_width_eff),
      .count    (w_h_count),
      .last     (w_h_last)
   );

   alt_vipitc131_common_wrap_counter #(
      .WIDTH (V_COUNT_WIDTH),
      .STEP  (1)
   ) u_v_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (w_eol),
      .sclr     (bus.sclr),
      .sclr_val ('0),
      .limit    (w_height_eff),
      .count    (w_v_count),
      .last     (w_v_last)
   );

   assign bus.count_sample    = w_count_sample;
   assign bus.start_of_sample = w_sos;
   assign bus.sample_ticks    = r_tick;
   assign bus.h_count         = w_h_count;
   assign bus.v_count         = w_v_count;
   assign bus.end_of_line     = w_eol;
   assign bus.end_of_frame    = w_eof;
   // During sclr the position is already the origin of the new frame.
   assign bus.start_of_frame  = w_sos & (bus.sclr | ((w_h_count == '0) & (w_v_count == '0)));
endmodule
`default_nettype wire
